// File: rtl/datapath_scheduler_if.sv
// Bus bundle between the per-thread engines, the datapath scheduler and the shared datapath.
// The stats outputs exist only when DATAPATH_SCHEDULER_STATS_EN is defined.
interface datapath_scheduler_if #(
   parameter int PORTS    = 4,
   parameter int INSTR_W  = 32,
   parameter int RESULT_W = 32
);
   logic [INSTR_W*PORTS-1:0]  instruction;
   logic [PORTS-1:0]          start;
   logic [RESULT_W*PORTS-1:0] result;
   logic [PORTS-1:0]          finished;
   logic [INSTR_W-1:0]        instruction_dp;
   logic                      start_dp;
   logic [RESULT_W-1:0]       result_dp;
   logic                      finished_dp;
   logic                      error;
`ifdef DATAPATH_SCHEDULER_STATS_EN
   logic [31:0]               issued_count;
   logic [31:0]               stall_cycles;
`endif

   modport master (
      output instruction, start, result_dp, finished_dp,
      input  result, finished, instruction_dp, start_dp, error
`ifdef DATAPATH_SCHEDULER_STATS_EN
      , input issued_count, stall_cycles
`endif
   );

   modport slave (
      input  instruction, start, result_dp, finished_dp,
      output result, finished, instruction_dp, start_dp, error
`ifdef DATAPATH_SCHEDULER_STATS_EN
      , output issued_count, stall_cycles
`endif
   );
endinterface

// File: rtl/datapath_scheduler.sv
// Round-robin sharing of one in-order pipelined datapath among PORTS requesters, with a tag FIFO
// steering results home. Optional saturating counters under DATAPATH_SCHEDULER_STATS_EN.
module datapath_scheduler #(
   parameter int PORTS    = 4,
   parameter int INSTR_W  = 32,
   parameter int RESULT_W = 32,
   parameter int DEPTH    = 4
) (
   input logic                 clock,
   input logic                 reset,
   datapath_scheduler_if.slave bus
);
   localparam int TW = $clog2(PORTS);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [TW:0]   PORTS_C = (TW+1)'(PORTS);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [INSTR_W-1:0]        instr_r [PORTS];
   logic [TW-1:0]             fifo_r [DEPTH];
   logic [PORTS-1:0]          pending_r;
   logic [PORTS-1:0]          finished_r;
   logic [PW-1:0]             wr_ptr_r;
   logic [PW-1:0]             rd_ptr_r;
   logic [CW-1:0]             count_r;
   logic [TW-1:0]             ptr_r;
   logic [RESULT_W*PORTS-1:0] result_r;
   logic [INSTR_W-1:0]        instruction_dp_r;
   logic                      start_dp_r;
   logic                      error_r;

   logic [PORTS-1:0]          accept_s;
   logic [PORTS-1:0]          grant_mask_s;
   logic [PORTS-1:0]          ret_mask_s;
   logic [TW:0]               sum_s;
   logic [TW-1:0]             idx_s;
   logic [TW-1:0]             grant_s;
   logic [TW-1:0]             pop_tag_s;
   logic                      found_s;
   logic                      push_s;
   logic                      pop_s;
   logic                      proto_err_s;

   // Accept, round-robin grant after ptr, FIFO push/pop decisions and protocol checks
   always_comb begin
      accept_s = bus.start & finished_r;
      sum_s    = '0;
      idx_s    = '0;
      grant_s  = '0;
      found_s  = 1'b0;
      for (int k = 1; k <= PORTS; k++) begin
         sum_s   = {1'b0, ptr_r} + (TW+1)'(k);
         idx_s   = TW'((sum_s >= PORTS_C) ? (sum_s - PORTS_C) : sum_s);
         grant_s = (!found_s && pending_r[idx_s]) ? idx_s : grant_s;
         found_s = found_s | pending_r[idx_s];
      end
      // Full is judged on the registered count, so a same-cycle pop cannot free a slot early
      push_s       = found_s && (count_r < DEPTH_C);
      pop_s        = bus.finished_dp && (count_r != '0);
      pop_tag_s    = fifo_r[rd_ptr_r];
      grant_mask_s = push_s ? (PORTS'(1'b1) << grant_s) : '0;
      ret_mask_s   = pop_s ? (PORTS'(1'b1) << pop_tag_s) : '0;
      proto_err_s  = ((bus.start & ~finished_r) != '0) ||
                     (bus.finished_dp && (count_r == '0));
   end

   // Request latching, issue to the datapath, tag FIFO and result steering
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PORTS; i++) begin
            instr_r[i] <= '0;
         end
         for (int d = 0; d < DEPTH; d++) begin
            fifo_r[d] <= '0;
         end
         pending_r        <= '0;
         finished_r       <= '1;
         wr_ptr_r         <= '0;
         rd_ptr_r         <= '0;
         count_r          <= '0;
         ptr_r            <= TW'(PORTS - 1);
         result_r         <= '0;
         instruction_dp_r <= '0;
         start_dp_r       <= 1'b0;
         error_r          <= 1'b0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (accept_s[i]) begin
               instr_r[i] <= bus.instruction[i*INSTR_W +: INSTR_W];
            end
         end
         pending_r  <= (pending_r & ~grant_mask_s) | accept_s;
         finished_r <= (finished_r & ~accept_s) | ret_mask_s;
         start_dp_r <= push_s;
         if (push_s) begin
            instruction_dp_r <= instr_r[grant_s];
            ptr_r            <= grant_s;
            fifo_r[wr_ptr_r] <= grant_s;
            wr_ptr_r         <= (wr_ptr_r == LAST_C) ? '0 : (wr_ptr_r + PW'(1));
         end
         if (pop_s) begin
            result_r[pop_tag_s*RESULT_W +: RESULT_W] <= bus.result_dp;
            rd_ptr_r <= (rd_ptr_r == LAST_C) ? '0 : (rd_ptr_r + PW'(1));
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
         if (proto_err_s) begin
            error_r <= 1'b1;
         end
      end
   end

   assign bus.result         = result_r;
   assign bus.finished       = finished_r;
   assign bus.instruction_dp = instruction_dp_r;
   assign bus.start_dp       = start_dp_r;
   assign bus.error          = error_r;

`ifdef DATAPATH_SCHEDULER_STATS_EN
   logic [31:0] issued_count_r;
   logic [31:0] stall_cycles_r;

   // Saturating issue and full-stall counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         issued_count_r <= 32'd0;
         stall_cycles_r <= 32'd0;
      end else begin
         if (start_dp_r && (issued_count_r != 32'hFFFF_FFFF)) begin
            issued_count_r <= issued_count_r + 32'd1;
         end
         if ((pending_r != '0) && (count_r == DEPTH_C) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end
      end
   end

   assign bus.issued_count = issued_count_r;
   assign bus.stall_cycles = stall_cycles_r;
`endif
endmodule

// File: tb/tb_datapath_scheduler.sv
// Directed bench for datapath_scheduler: DUT a uses DEPTH=4, DUT b uses DEPTH=2 for the full-stall case.
module tb_datapath_scheduler;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] ord_q[$];
   int          ocyc_q[$];
   logic [31:0] rv_q[$];
   int          due_q[$];

   always #5 clock = ~clock;

   datapath_scheduler_if #(.PORTS(4), .INSTR_W(32), .RESULT_W(32)) ifa ();
   datapath_scheduler_if #(.PORTS(4), .INSTR_W(32), .RESULT_W(32)) ifb ();

   datapath_scheduler #(.PORTS(4), .INSTR_W(32), .RESULT_W(32), .DEPTH(4)) dut_a (
      .clock(clock), .reset(reset), .bus(ifa));
   datapath_scheduler #(.PORTS(4), .INSTR_W(32), .RESULT_W(32), .DEPTH(2)) dut_b (
      .clock(clock), .reset(reset), .bus(ifb));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      ifa.start = 4'b0000; ifa.finished_dp = 1'b0;
      ifb.start = 4'b0000; ifb.finished_dp = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Runs dut_a with an in-order datapath model returning instr^A5A50000 two cycles after issue
   task automatic run_a(input int ncyc);
      ord_q.delete(); ocyc_q.delete(); rv_q.delete(); due_q.delete();
      for (int c = 0; c < ncyc; c++) begin
         ifa.finished_dp = 1'b0;
         if ((due_q.size() > 0) && (due_q[0] == c)) begin
            ifa.finished_dp = 1'b1;
            ifa.result_dp   = rv_q.pop_front();
            void'(due_q.pop_front());
         end
         tick();
         if (ifa.start_dp === 1'b1) begin
            ord_q.push_back(ifa.instruction_dp);
            ocyc_q.push_back(c);
            rv_q.push_back(ifa.instruction_dp ^ 32'hA5A5_0000);
            due_q.push_back(c + 2);
         end
      end
      ifa.finished_dp = 1'b0;
   endtask

   task automatic check_order(input string tag, input logic [31:0] base);
      logic [31:0] got;
      int          span;
      chk({tag, " issues"}, ord_q.size(), 128'd4);
      for (int i = 0; i < 4; i++) begin
         got = (i < ord_q.size()) ? ord_q[i] : 32'hxxxx_xxxx;
         chk({tag, " order"}, got, base + 32'(i));
      end
      span = (ocyc_q.size() == 4) ? (ocyc_q[3] - ocyc_q[0]) : -1;
      chk({tag, " back2back"}, span, 128'd3);
   endtask

   initial begin
      int pulses;
      reset = 1'b1;
      ifa.instruction = '0; ifa.start = 4'b0000; ifa.result_dp = 32'd0; ifa.finished_dp = 1'b0;
      ifb.instruction = '0; ifb.start = 4'b0000; ifb.result_dp = 32'd0; ifb.finished_dp = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst result", ifa.result, 128'd0);
      chk("rst finished", ifa.finished, 4'b1111);
      chk("rst instr_dp", ifa.instruction_dp, 32'd0);
      chk("rst start_dp", ifa.start_dp, 1'b0);
      chk("rst error", ifa.error, 1'b0);
      chk("rst b finished", ifb.finished, 4'b1111);

      // Test 1: single request on port 0
      ifa.instruction = {32'h0, 32'h0, 32'h0, 32'h11};
      ifa.start = 4'b0001;
      tick();
      ifa.start = 4'b0000;
      chk("t1 finished low", ifa.finished, 4'b1110);
      chk("t1 no early issue", ifa.start_dp, 1'b0);
      tick();
      chk("t1 start_dp", ifa.start_dp, 1'b1);
      chk("t1 instr_dp", ifa.instruction_dp, 32'h11);
      tick();
      chk("t1 start_dp one cycle", ifa.start_dp, 1'b0);
      chk("t1 instr_dp held", ifa.instruction_dp, 32'h11);
      tick();
      ifa.finished_dp = 1'b1; ifa.result_dp = 32'hAA;
      tick();
      ifa.finished_dp = 1'b0;
      chk("t1 result", ifa.result, 128'hAA);
      chk("t1 finished", ifa.finished, 4'b1111);
      chk("t1 error", ifa.error, 1'b0);

      // Test 2: fairness, two bursts of all four ports
      do_reset();
      ifa.instruction = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
      ifa.start = 4'b1111;
      tick();
      ifa.start = 4'b0000;
      chk("t2 finished low", ifa.finished, 4'b0000);
      run_a(10);
      check_order("t2a", 32'h1000);
      chk("t2a result", ifa.result, {32'hA5A51003, 32'hA5A51002, 32'hA5A51001, 32'hA5A51000});
      chk("t2a finished", ifa.finished, 4'b1111);
      ifa.instruction = {32'h2003, 32'h2002, 32'h2001, 32'h2000};
      ifa.start = 4'b1111;
      tick();
      ifa.start = 4'b0000;
      run_a(10);
      check_order("t2b", 32'h2000);
      chk("t2b result", ifa.result, {32'hA5A52003, 32'hA5A52002, 32'hA5A52001, 32'hA5A52000});
      chk("t2b error", ifa.error, 1'b0);

      // Test 3: full stall on the DEPTH=2 instance
      do_reset();
      ifb.instruction = {32'h33, 32'h32, 32'h31, 32'h30};
      ifb.start = 4'b1111;
      tick();
      ifb.start = 4'b0000;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ifb.start_dp === 1'b1) pulses++;
      end
      chk("t3 pulses when full", pulses, 128'd2);
      chk("t3 instr_dp held", ifb.instruction_dp, 32'h31);
      ifb.finished_dp = 1'b1; ifb.result_dp = 32'hB0;
      tick();
      ifb.finished_dp = 1'b0;
      chk("t3 no issue on pop edge", ifb.start_dp, 1'b0);
      chk("t3 finished", ifb.finished, 4'b0001);
      chk("t3 result", ifb.result, 128'hB0);
      tick();
      chk("t3 reissue", ifb.start_dp, 1'b1);
      chk("t3 reissue port2", ifb.instruction_dp, 32'h32);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (ifb.start_dp === 1'b1) pulses++;
      end
      chk("t3 no further issue", pulses, 128'd0);
      chk("t3 error", ifb.error, 1'b0);

      // Test 4: port 2 then port 0, results steered in order
      do_reset();
      ifa.instruction = {32'h0, 32'h42, 32'h0, 32'h40};
      ifa.start = 4'b0100;
      tick();
      ifa.start = 4'b0001;
      tick();
      ifa.start = 4'b0000;
      chk("t4 first issue", ifa.instruction_dp, 32'h42);
      tick();
      chk("t4 second start", ifa.start_dp, 1'b1);
      chk("t4 second issue", ifa.instruction_dp, 32'h40);
      ifa.finished_dp = 1'b1; ifa.result_dp = 32'h22;
      tick();
      chk("t4 finished2 first", ifa.finished, 4'b1110);
      chk("t4 slot2", ifa.result, 128'h00000000_00000022_00000000_00000000);
      ifa.result_dp = 32'h00;
      tick();
      ifa.finished_dp = 1'b0;
      chk("t4 finished all", ifa.finished, 4'b1111);
      chk("t4 error", ifa.error, 1'b0);

      // Test 5: repeated start while busy, then stray finished_dp after reset
      ifa.instruction = {32'h0, 32'h0, 32'h51, 32'h0};
      ifa.start = 4'b0010;
      tick();
      tick();
      ifa.start = 4'b0000;
      chk("t5 error busy start", ifa.error, 1'b1);
      chk("t5 issue", ifa.instruction_dp, 32'h51);
      tick();
      chk("t5 no extra issue a", ifa.start_dp, 1'b0);
      tick();
      chk("t5 no extra issue b", ifa.start_dp, 1'b0);
      do_reset();
      chk("t5 error cleared", ifa.error, 1'b0);
      ifa.finished_dp = 1'b1; ifa.result_dp = 32'hDEAD;
      tick();
      ifa.finished_dp = 1'b0;
      chk("t5 stray error", ifa.error, 1'b1);
      chk("t5 stray result", ifa.result, 128'd0);
      chk("t5 stray finished", ifa.finished, 4'b1111);

      // Test 6: async reset with two in flight
      do_reset();
      ifa.instruction = {32'h63, 32'h0, 32'h61, 32'h60};
      ifa.start = 4'b0011;
      tick();
      ifa.start = 4'b0000;
      tick();
      chk("t6 issue0", ifa.instruction_dp, 32'h60);
      tick();
      chk("t6 issue1", ifa.instruction_dp, 32'h61);
      reset = 1'b1;
      #1;
      chk("t6 async finished", ifa.finished, 4'b1111);
      chk("t6 async start_dp", ifa.start_dp, 1'b0);
      chk("t6 async instr_dp", ifa.instruction_dp, 32'd0);
      tick();
      reset = 1'b0;
      ifa.finished_dp = 1'b1; ifa.result_dp = 32'h99;
      tick();
      ifa.finished_dp = 1'b0;
      chk("t6 late return error", ifa.error, 1'b1);
      chk("t6 late return result", ifa.result, 128'd0);
      ifa.start = 4'b1000;
      tick();
      ifa.start = 4'b0000;
      chk("t6 finished3 low", ifa.finished, 4'b0111);
      tick();
      chk("t6 start3", ifa.start_dp, 1'b1);
      chk("t6 instr3", ifa.instruction_dp, 32'h63);
      tick();
      ifa.finished_dp = 1'b1; ifa.result_dp = 32'h36;
      tick();
      ifa.finished_dp = 1'b0;
      chk("t6 result3", ifa.result, 128'h00000036_00000000_00000000_00000000);
      chk("t6 finished", ifa.finished, 4'b1111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
